// File: rtl/arcade_input_conditioner_if.sv
// Player-input bus between the raw button mux and the conditioner.
// The slave modport is the conditioner's side; the master modport is the producer/observer side.
interface arcade_input_conditioner_if #(
  parameter int unsigned NBTN = 10
);
  logic [NBTN-1:0] joy_in;
  logic [NBTN-1:0] btn_stable;
  logic [NBTN-1:0] btn_rise;
  logic            btn_left;
  logic            btn_right;
  logic            coin_out;
  logic [2:0]      coin_pending;
  logic            pause_active;

  modport master (
    output joy_in,
    input  btn_stable, btn_rise, btn_left, btn_right, coin_out, coin_pending, pause_active
  );

  modport slave (
    input  joy_in,
    output btn_stable, btn_rise, btn_left, btn_right, coin_out, coin_pending, pause_active
  );
endinterface

// File: rtl/arcade_input_conditioner.sv
// Synchronises and debounces player buttons, resolves L+R, shapes queued coin pulses
// and turns the Pause button into a toggled level.
module arcade_input_conditioner #(
  parameter int unsigned NBTN       = 10,
  parameter int unsigned DEB_COUNT  = 11000,
  parameter int unsigned COIN_PULSE = 110000,
  parameter int unsigned COIN_GAP   = 110000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  arcade_input_conditioner_if.slave bus
);
  localparam int unsigned CoinBit  = 8;
  localparam int unsigned PauseBit = 9;
  localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEB_COUNT - 1);
  localparam logic [CNT_W-1:0] PulseLast = CNT_W'(COIN_PULSE - 1);
  localparam logic [CNT_W-1:0] GapLast   = CNT_W'(COIN_GAP - 1);

  typedef enum logic [1:0] {StIdle, StPulse, StGap} coin_state_e;

  logic [NBTN-1:0]  meta_q, sync_q;
  logic [NBTN-1:0]  stable_q, stable_d, stable_dly_q, rise_q;
  logic [CNT_W-1:0] deb_cnt_q [NBTN];
  logic [CNT_W-1:0] deb_cnt_d [NBTN];
  logic             pause_q;

  coin_state_e      state_q;
  logic [CNT_W-1:0] coin_cnt_q;
  logic             coin_q;
  logic [2:0]       pending_q, pending_d;
  logic             launch_pend, push;

  always_comb begin
    for (int i = 0; i < int'(NBTN); i++) begin
      stable_d[i]  = stable_q[i];
      deb_cnt_d[i] = '0;
      if (sync_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          stable_d[i] = sync_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q       <= '0;
      sync_q       <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      rise_q       <= '0;
      pause_q      <= 1'b0;
      for (int i = 0; i < int'(NBTN); i++) deb_cnt_q[i] <= '0;
    end else begin
      meta_q       <= bus.joy_in;
      sync_q       <= meta_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      rise_q       <= stable_q & ~stable_dly_q;
      pause_q      <= pause_q ^ rise_q[PauseBit];
      deb_cnt_q    <= deb_cnt_d;
    end
  end

  // A rise arriving while IDLE launches from the queue is queued behind it (net zero).
  always_comb begin
    launch_pend = (state_q == StIdle) && (pending_q != 3'd0);
    push        = rise_q[CoinBit] && ((state_q != StIdle) || launch_pend);
    pending_d   = pending_q;
    if (push && !launch_pend && (pending_q != 3'd7)) begin
      pending_d = pending_q + 3'd1;
    end else if (launch_pend && !push) begin
      pending_d = pending_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      coin_cnt_q <= '0;
      coin_q     <= 1'b0;
      pending_q  <= 3'd0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        StIdle: begin
          if (rise_q[CoinBit] || (pending_q != 3'd0)) begin
            state_q    <= StPulse;
            coin_cnt_q <= '0;
            coin_q     <= 1'b1;
          end
        end
        StPulse: begin
          if (coin_cnt_q == PulseLast) begin
            state_q    <= StGap;
            coin_cnt_q <= '0;
            coin_q     <= 1'b0;
          end else begin
            coin_cnt_q <= coin_cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (coin_cnt_q == GapLast) begin
            state_q    <= StIdle;
            coin_cnt_q <= '0;
          end else begin
            coin_cnt_q <= coin_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          coin_cnt_q <= '0;
          coin_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.btn_stable   = stable_q;
  assign bus.btn_rise     = rise_q;
  assign bus.btn_left     = stable_q[1] & ~stable_q[0];
  assign bus.btn_right    = stable_q[0] & ~stable_q[1];
  assign bus.coin_out     = coin_q;
  assign bus.coin_pending = pending_q;
  assign bus.pause_active = pause_q;

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Directed bench for arcade_input_conditioner: vector table for debounce/SOCD/pause plus
// hand-written coin-queue and reset sequences.
module tb_arcade_input_conditioner;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] joy = '0;

  always #5 clk = ~clk;

  arcade_input_conditioner_if #(.NBTN(10)) bus_a ();
  arcade_input_conditioner_if #(.NBTN(10)) bus_b ();
  assign bus_a.joy_in = joy;
  assign bus_b.joy_in = joy;

  arcade_input_conditioner #(
    .NBTN(10), .DEB_COUNT(4), .COIN_PULSE(8), .COIN_GAP(4), .CNT_W(8)
  ) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  // Long pulse so that many 8-cycle debounced presses land inside a single pulse.
  arcade_input_conditioner #(
    .NBTN(10), .DEB_COUNT(4), .COIN_PULSE(100), .COIN_GAP(4), .CNT_W(8)
  ) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] joy;
    logic [9:0] stable;
    logic [1:0] lr;
    logic       pause;
  } vec_t;
  vec_t vecs [9];

  // Coin monitor on dut_b.
  bit         mon_en = 1'b0;
  int         pulses, low_len, low_min, low_max;
  logic [2:0] pend_max;
  logic       coin_prev = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_b.coin_out) begin
        if (!coin_prev) begin
          pulses++;
          if (pulses > 1) begin
            if (low_len < low_min) low_min = low_len;
            if (low_len > low_max) low_max = low_len;
          end
        end
        low_len = 0;
      end else begin
        low_len++;
      end
      if (bus_b.coin_pending > pend_max) pend_max = bus_b.coin_pending;
    end
    coin_prev = bus_b.coin_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input int b);
    joy[b] = 1'b1;
    repeat (4) tick();
    joy[b] = 1'b0;
    repeat (4) tick();
  endtask

  task automatic mon_reset();
    mon_en   = 1'b0;
    pulses   = 0;
    low_len  = 0;
    low_min  = 1000;
    low_max  = 0;
    pend_max = '0;
    mon_en   = 1'b1;
  endtask

  task automatic drain(input int n);
    int t = 0;
    while (!(pulses == n && !bus_b.coin_out && bus_b.coin_pending == 3'd0) && t < 2000) begin
      tick();
      t++;
    end
    check("drain_in_budget", 32'(t < 2000), 32'd1);
    repeat (30) tick();
  endtask

  initial begin
    int hi;
    logic [2:0] pmax;
    bit seen;

    vecs[0] = '{joy: 10'h010, stable: 10'h010, lr: 2'b00, pause: 1'b0};
    vecs[1] = '{joy: 10'h003, stable: 10'h003, lr: 2'b00, pause: 1'b0};
    vecs[2] = '{joy: 10'h002, stable: 10'h002, lr: 2'b10, pause: 1'b0};
    vecs[3] = '{joy: 10'h001, stable: 10'h001, lr: 2'b01, pause: 1'b0};
    vecs[4] = '{joy: 10'h200, stable: 10'h200, lr: 2'b00, pause: 1'b1};
    vecs[5] = '{joy: 10'h000, stable: 10'h000, lr: 2'b00, pause: 1'b1};
    vecs[6] = '{joy: 10'h200, stable: 10'h200, lr: 2'b00, pause: 1'b0};
    vecs[7] = '{joy: 10'h0C0, stable: 10'h0C0, lr: 2'b00, pause: 1'b0};
    vecs[8] = '{joy: 10'h000, stable: 10'h000, lr: 2'b00, pause: 1'b0};

    // Reset state
    tick();
    tick();
    check("rst_stable", bus_a.btn_stable, 0);
    check("rst_rise", bus_a.btn_rise, 0);
    check("rst_lr", {bus_a.btn_left, bus_a.btn_right}, 0);
    check("rst_coin", bus_a.coin_out, 0);
    check("rst_pending", bus_a.coin_pending, 0);
    check("rst_pause", bus_a.pause_active, 0);
    reset = 1'b0;

    // Bounce: 3-cycle glitch never reaches stable
    joy[4] = 1'b1;
    repeat (3) begin tick(); check("bounce_hi", bus_a.btn_stable[4], 0); end
    joy[4] = 1'b0;
    repeat (10) begin tick(); check("bounce_lo", bus_a.btn_stable[4], 0); end

    // Held press: stable at cycle 6, rise for exactly one cycle
    joy[4] = 1'b1;
    repeat (5) tick();
    check("hold_c5_stable", bus_a.btn_stable[4], 0);
    tick();
    check("hold_c6_stable", bus_a.btn_stable[4], 1);
    check("hold_c6_rise", bus_a.btn_rise[4], 0);
    tick();
    check("hold_c7_rise", bus_a.btn_rise[4], 1);
    tick();
    check("hold_c8_rise", bus_a.btn_rise[4], 0);
    joy = '0;
    repeat (8) tick();

    // SOCD: L+R neutral, release R -> left once R debounced
    joy = 10'h003;
    repeat (8) tick();
    check("socd_both", {bus_a.btn_left, bus_a.btn_right}, 2'b00);
    joy = 10'h002;
    repeat (5) tick();
    check("socd_c5", {bus_a.btn_left, bus_a.btn_right}, 2'b00);
    tick();
    check("socd_c6", {bus_a.btn_left, bus_a.btn_right}, 2'b10);
    joy = '0;
    repeat (8) tick();

    // Vector table
    for (int i = 0; i < 9; i++) begin
      joy = vecs[i].joy;
      repeat (8) tick();
      check($sformatf("vec%0d_stable", i), bus_a.btn_stable, vecs[i].stable);
      check($sformatf("vec%0d_rise", i), bus_a.btn_rise, 0);
      check($sformatf("vec%0d_lr", i), {bus_a.btn_left, bus_a.btn_right}, vecs[i].lr);
      check($sformatf("vec%0d_pause", i), bus_a.pause_active, vecs[i].pause);
    end

    // Single coin on dut_a: launch 8 cycles after press, 8 high, then stays low
    joy[8] = 1'b1;
    repeat (4) tick();
    joy[8] = 1'b0;
    repeat (3) tick();
    check("coin_c7", bus_a.coin_out, 0);
    tick();
    check("coin_c8", bus_a.coin_out, 1);
    hi = 1;
    pmax = bus_a.coin_pending;
    while (bus_a.coin_out && hi < 50) begin
      tick();
      if (bus_a.coin_pending > pmax) pmax = bus_a.coin_pending;
      if (bus_a.coin_out) hi++;
    end
    check("coin_high_len", hi, 8);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (bus_a.coin_out) seen = 1'b1;
      if (bus_a.coin_pending > pmax) pmax = bus_a.coin_pending;
    end
    check("coin_low_after", seen, 0);
    check("coin_pending_max", pmax, 0);
    repeat (100) tick();
    check("b_idle_coin", bus_b.coin_out, 0);
    check("b_idle_pending", bus_b.coin_pending, 0);

    // Burst on dut_b: one launching press + 3 during pulse -> 4 pulses
    mon_reset();
    repeat (4) press(8);
    drain(4);
    check("burst_pulses", pulses, 4);
    check("burst_pend_max", pend_max, 3);
    check("burst_gap_min_ok", 32'(low_min >= 4), 1);
    check("burst_gap_max_ok", 32'(low_max <= 5), 1);

    // Saturation on dut_b: one launching press + 10 during pulse -> 8 pulses
    mon_reset();
    repeat (11) press(8);
    drain(8);
    check("sat_pulses", pulses, 8);
    check("sat_pend_max", pend_max, 7);
    mon_en = 1'b0;

    // Reset mid-pulse with two queued, Barrier held through reset
    press(9);
    check("pause_on", bus_a.pause_active, 1);
    repeat (3) press(8);
    check("pre_rst_b_coin", bus_b.coin_out, 1);
    check("pre_rst_b_pending", bus_b.coin_pending, 2);
    joy = 10'h020;
    reset = 1'b1;
    tick();
    check("mid_rst_b_coin", bus_b.coin_out, 0);
    check("mid_rst_b_pending", bus_b.coin_pending, 0);
    check("mid_rst_a_pause", bus_a.pause_active, 0);
    check("mid_rst_b_pause", bus_b.pause_active, 0);
    check("mid_rst_stable", bus_b.btn_stable, 0);
    reset = 1'b0;
    repeat (5) tick();
    check("held_c5_stable", bus_b.btn_stable, 0);
    tick();
    check("held_c6_stable", bus_b.btn_stable, 10'h020);
    tick();
    check("held_c7_rise", bus_b.btn_rise, 10'h020);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (bus_b.coin_out || bus_b.coin_pending != 3'd0) seen = 1'b1;
    end
    check("post_rst_idle", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
